uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//  Serial UART receiver, 8N1, LSB first, 16x oversampled. Input is the board UART_RXD pin.
//  Delivers each received byte to board logic (LEDs, LCD digit registers) as one-cycle strobes.
//  This is the receive end of the serial link; the board drives UART_TXD.
//  Runs on CLOCK_50. Reset comes from KEY[0].
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency (Hz)
//  BAUD        115200      line rate (bit/s)
//  OVERSAMPLE  16          sample ticks per bit; must be an even number >= 8
//  DATA_BITS   8           data bits per frame (5..8)
// PORTS
//  iCLK        in   1          system clock (CLOCK_50)
//  iRST_N      in   1          asynchronous active-low reset
//  iRXD        in   1          asynchronous serial line; idle high
//  oDATA       out  DATA_BITS  last good byte; holds until the next good byte
//  oVALID      out  1          one-cycle strobe: oDATA updated this cycle
//  oFRAME_ERR  out  1          one-cycle strobe: stop bit sampled low
//  oBUSY       out  1          high from start-bit detect until return to IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): oDATA=0, oVALID=0, oFRAME_ERR=0, oBUSY=0, state=IDLE.
//    Sync flops reset to 1; tick divider and counters reset to 0.
//  - Synchroniser: iRXD passes through 2 flops into rxd_s. No other logic reads iRXD.
//  - Tick: DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)) clocks per tick; 50M/115200/16 -> DIV=27.
//    One bit = OVERSAMPLE ticks = 432 clocks at defaults.
//    The divider free-runs in IDLE. It restarts at 0 on start-bit detect, so bit alignment is exact.
//  - Mid-bit sample = majority of 3 samples at ticks M-1, M, M+1, where M = OVERSAMPLE/2.
//  - FSM:
//    IDLE:  rxd_s==0 -> START; restart divider and tick counter; oBUSY=1.
//    START: majority at mid-bit ==1 -> glitch, go to IDLE, no strobes.
//           Majority ==0 -> restart tick count, go to DATA, bit_idx=0.
//    DATA:  at each mid-bit, shift the majority bit into the MSB of shreg (LSB-first line order).
//           After DATA_BITS bits -> STOP.
//    STOP:  at mid-bit: majority==1 -> oDATA<=shreg, oVALID=1 for one clock, go to IDLE.
//           Majority==0 -> oFRAME_ERR=1 for one clock, oDATA unchanged, go to BREAK.
//    BREAK: wait for rxd_s==1, then go to IDLE. oBUSY stays 1 throughout.
//  - Latency: strobe is asserted 1 clock after the stop-bit M+1 tick.
//    Return to IDLE is in the same clock, so a start edge half a bit later is caught (no gap needed).
//  - oVALID and oFRAME_ERR are never high in the same cycle. There is no back-pressure.
//    A consumer that misses a strobe loses that byte. oDATA remains readable until the next good frame.
//  - Reset mid-frame aborts immediately: no strobe, and shreg contents are discarded.
//  - Line held low forever: one frame error, then BREAK until the line goes high.
//  - Arithmetic: tick counter is clog2(OVERSAMPLE) bits and wraps at OVERSAMPLE-1.
//    bit_idx is clog2(DATA_BITS+1) bits. Divider counter is clog2(DIV) bits, with no overflow.
// STRUCTURE
//  - uart_defs.vh: FSM state encodings (IDLE, START, DATA, STOP, BREAK) and default BAUD/OVERSAMPLE.
//    Shared with the future uart_tx_byte.
//  - Sub-module uart_baud_tick: parameter DIV; ports iCLK, iRST_N, iRESTART; output oTICK.
//    oTICK is a one-clock pulse every DIV clocks. Reused by uart_tx_byte.
//  - Top level: 2-flop synchroniser, FSM, majority voter, shift register.
// TESTING (CLK_HZ=50M, BAUD=115200, bit = 432 clocks)
//  1. Send 0x55, 8N1, then idle high -> exactly one oVALID pulse, oDATA=0x55, oFRAME_ERR stays 0.
//  2. Low glitch of 100 clocks on an idle line -> no strobes; oBUSY drops within 1 bit time;
//     a following 0xC3 frame is received correctly.
//  3. 0x55 good, then 0xA3 with stop bit=0 -> one oFRAME_ERR pulse, no oVALID, oDATA stays 0x55.
//     oBUSY stays high until the line returns high.
//  4. Back-to-back 0x00 then 0xFF, no idle between frames -> two oVALID pulses, 0x00 then 0xFF.
//  5. Assert iRST_N low during data bit 4 of 0x96 -> all outputs 0 at once.
//     After release, frame 0x3C -> oVALID with oDATA=0x3C.
//  6. Transmitter bit time at 432*1.03 and at 432*0.97 clocks, bytes 0x01 and 0x80
//     -> both received correctly, no frame errors.

Source files
------------

// File: rtl/uart_rx_byte_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings, divider helper.
// Meant to be imported by both the receiver and the future transmitter.
package uart_rx_byte_pkg;

  localparam int DEF_BAUD       = 115200;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  typedef struct packed {
    logic valid;
    logic frame_err;
  } rx_evt_t;

  // Rounded clocks per oversample tick.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running tick divider: one-clock pulse every DIV clocks, restartable at 0.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iRESTART,
  output logic oTICK
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign oTICK = (cnt == CW'(DIV - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)                cnt <= '0;
    else if (iRESTART || oTICK) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, 16x oversampled, 3-sample majority vote at mid-bit.
// Delivers each byte as a one-cycle strobe; stop-bit errors park in BREAK until the line idles.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iRXD,
  output logic [DATA_BITS-1:0] oDATA,
  output logic                 oVALID,
  output logic                 oFRAME_ERR,
  output logic                 oBUSY
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  logic [1:0]           rst_sync;
  logic                 rst_n;
  logic [1:0]           rxd_sync;
  logic                 rxd_s;
  logic                 tick;
  logic                 restart;
  logic [TW-1:0]        tcnt;
  logic                 samp_a, samp_b, maj, mid_end;
  logic                 shift_en;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg, data_q;
  rx_evt_t              evt, evt_nxt;
  rx_state_e            state, state_nxt;

  // Async assert, sync release of the internal reset.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) rxd_sync <= '1;
    else        rxd_sync <= {rxd_sync[0], iRXD};
  end
  assign rxd_s = rxd_sync[1];

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .iCLK     (iCLK),
    .iRST_N   (rst_n),
    .iRESTART (restart),
    .oTICK    (tick)
  );

  // Third vote is the live sample on the M+1 tick.
  assign mid_end = tick && (tcnt == TW'(M + 1));
  assign maj     = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);

  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!rxd_s)  state_nxt = ST_START;
      ST_START: if (mid_end) state_nxt = maj ? ST_IDLE : ST_DATA;
      ST_DATA:  if (mid_end && bit_idx == BW'(DATA_BITS - 1)) state_nxt = ST_STOP;
      ST_STOP:  if (mid_end) state_nxt = maj ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rxd_s)   state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    restart  = 1'b0;
    shift_en = 1'b0;
    evt_nxt  = '0;
    unique case (state)
      ST_IDLE: restart  = ~rxd_s;
      ST_DATA: shift_en = mid_end;
      ST_STOP: begin
        evt_nxt.valid     = mid_end &  maj;
        evt_nxt.frame_err = mid_end & ~maj;
      end
      default: ;
    endcase
  end

  // Divider is aligned at the start edge, so the tick count simply wraps per bit.
  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      samp_a  <= 1'b0;
      samp_b  <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      evt     <= '0;
    end else begin
      evt <= evt_nxt;
      if (restart)   tcnt <= '0;
      else if (tick) tcnt <= (tcnt == TW'(OVERSAMPLE - 1)) ? '0 : tcnt + 1'b1;
      if (tick && tcnt == TW'(M - 1)) samp_a <= rxd_s;
      if (tick && tcnt == TW'(M))     samp_b <= rxd_s;
      if (state == ST_START) bit_idx <= '0;
      else if (shift_en) begin
        shreg   <= {maj, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (evt_nxt.valid) data_q <= shreg;
    end
  end

  assign oDATA      = data_q;
  assign oVALID     = evt.valid;
  assign oFRAME_ERR = evt.frame_err;
  assign oBUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: table of frames plus hand sequences, strobes checked via scoreboard.
module tb_uart_rx_byte;

  localparam int BT = 432;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data;
  logic       valid, ferr, busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_good = 8'h00;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bt;
    int         idle;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vec[8];

  always #10 clk = ~clk;

  uart_rx_byte dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iRXD       (rxd),
    .oDATA      (data),
    .oVALID     (valid),
    .oFRAME_ERR (ferr),
    .oBUSY      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int bt);
    rxd = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bt) @(negedge clk);
    end
    rxd = stop;
    repeat (bt) @(negedge clk);
  endtask

  task automatic push_exp(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
    check(name, sb_q.size(), 0);
  endtask

  // Scoreboard: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (valid || ferr)) begin
      check("strobe_exclusive", {31'b0, valid & ferr}, 0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=%02h, none expected",
                 valid, ferr, data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("strobe_kind", {31'b0, ferr}, {31'b0, e.is_err});
        check("strobe_data", {24'b0, data}, {24'b0, e.data});
      end
    end
  end

  initial begin
    vec[0] = '{8'h55, 1'b1, BT,   300, 1'b0, 8'h55};
    vec[1] = '{8'h00, 1'b1, BT,   0,   1'b0, 8'h00};
    vec[2] = '{8'hFF, 1'b1, BT,   300, 1'b0, 8'hFF};
    vec[3] = '{8'h01, 1'b1, 445,  300, 1'b0, 8'h01};
    vec[4] = '{8'h80, 1'b1, 445,  300, 1'b0, 8'h80};
    vec[5] = '{8'h01, 1'b1, 419,  300, 1'b0, 8'h01};
    vec[6] = '{8'h80, 1'b1, 419,  300, 1'b0, 8'h80};
    vec[7] = '{8'hA5, 1'b1, BT,   300, 1'b0, 8'hA5};

    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data",  {24'b0, data}, 0);
    check("rst_valid", {31'b0, valid}, 0);
    check("rst_ferr",  {31'b0, ferr}, 0);
    check("rst_busy",  {31'b0, busy}, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Good frames: single byte, back-to-back pair, +/-3% transmitter bit time.
    for (int i = 0; i < 8; i++) begin
      push_exp(vec[i].exp_err, vec[i].exp_data);
      if (!vec[i].exp_err) last_good = vec[i].exp_data;
      send_byte(vec[i].data, vec[i].stop, vec[i].bt);
      rxd = 1'b1;
      if (vec[i].idle > 0) begin
        repeat (vec[i].idle) @(negedge clk);
        check($sformatf("vec%0d_drain", i), sb_q.size(), 0);
        check($sformatf("vec%0d_data", i), {24'b0, data}, {24'b0, vec[i].exp_data});
      end
    end

    // Short low glitch: rejected, busy clears within one bit time.
    rxd = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch_busy_hi", {31'b0, busy}, 1);
    repeat (50) @(negedge clk);
    rxd = 1'b1;
    begin
      int n = 100;
      while (busy && n < BT) begin
        @(negedge clk);
        n++;
      end
    end
    check("glitch_busy_lo", {31'b0, busy}, 0);
    repeat (BT) @(negedge clk);
    push_exp(1'b0, 8'hC3);
    last_good = 8'hC3;
    send_byte(8'hC3, 1'b1, BT);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    wait_drain("c3_drain");

    // Good 0x55, then 0xA3 with a low stop bit and the line held low.
    push_exp(1'b0, 8'h55);
    last_good = 8'h55;
    send_byte(8'h55, 1'b1, BT);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    push_exp(1'b1, last_good);
    send_byte(8'hA3, 1'b0, BT);
    repeat (3000) @(negedge clk);
    wait_drain("ferr_drain");
    check("break_busy", {31'b0, busy}, 1);
    check("break_data", {24'b0, data}, 8'h55);
    rxd = 1'b1;
    begin
      int n = 0;
      while (busy && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    check("break_exit", {31'b0, busy}, 0);
    repeat (300) @(negedge clk);

    // Reset during data bit 4 of 0x96.
    rxd = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = (8'h96 >> i) & 8'h01;
      repeat (BT) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("midframe_busy", {31'b0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("abort_data",  {24'b0, data}, 0);
    check("abort_valid", {31'b0, valid}, 0);
    check("abort_ferr",  {31'b0, ferr}, 0);
    check("abort_busy",  {31'b0, busy}, 0);
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * BT) @(negedge clk);
    check("post_rst_quiet", sb_q.size(), 0);
    push_exp(1'b0, 8'h3C);
    send_byte(8'h3C, 1'b1, BT);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    wait_drain("final_drain");
    check("final_data", {24'b0, data}, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
